// File: rtl/countdown_timer_pkg.sv
// Shared oven-stage definitions: timer state encoding, BCD digit limits and
// the default tick divider.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_DONE    = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS     = 4'd5;
  localparam int         DEFAULT_TICK_DIV = 0;
  localparam int         NUM_DIGITS       = 4;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX_ONES;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD digit of a chained down-counter: decrements on borrow_in and
// wraps 0 -> max, passing the borrow to the next more-significant digit.
module bcd_digit_down (
  input  logic [3:0] value,
  input  logic [3:0] max,
  input  logic       borrow_in,
  output logic [3:0] next_value,
  output logic       borrow_out
);

  always_comb begin
    next_value = value;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (value == 4'd0) begin
        next_value = max;
        borrow_out = 1'b1;
      end else begin
        next_value = value - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Microwave mm:ss countdown timer with keypad shift-in entry, pause on
// enable low, and a one-cycle completion strobe.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);

  // Index 0 = sec_ones ... index 3 = min_tens.
  logic [NUM_DIGITS-1:0][3:0] digits, digits_nx, dec;
  logic [NUM_DIGITS:0]        borrow;
  timer_state_t               state, state_nx;
  logic                       done_nx;
  logic                       tick_eff;
  logic                       time_zero;
  logic                       do_count;
  logic                       do_entry;

  generate
    if (TICK_DIV > 0) begin : g_int_tick
      localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
      localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pre;

      always_ff @(posedge clk) begin
        if (rst || !clearn)  pre <= '0;
        else if (enable)     pre <= (pre == LAST) ? '0 : pre + PW'(1);
      end

      assign tick_eff = enable && (pre == LAST);
    end else begin : g_ext_tick
      assign tick_eff = tick;
    end
  endgenerate

  // Borrow ripples out of the top digit only when every digit is zero.
  assign borrow[0] = 1'b1;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      localparam logic [3:0] MAXV = (i % 2 == 1) ? BCD_MAX_TENS : BCD_MAX_ONES;
      bcd_digit_down u_digit (
        .value      (digits[i]),
        .max        (MAXV),
        .borrow_in  (borrow[i]),
        .next_value (dec[i]),
        .borrow_out (borrow[i+1])
      );
    end
  endgenerate

  assign time_zero = (digits == '0);
  assign do_count  = tick_eff && enable && !borrow[NUM_DIGITS];
  assign do_entry  = !enable && digit_valid && is_bcd(digit) && (state != ST_RUNNING);

  always_comb begin
    digits_nx = digits;
    state_nx  = state;
    done_nx   = 1'b0;
    if (!clearn) begin
      digits_nx = '0;
      state_nx  = ST_IDLE;
    end else if (do_count) begin
      digits_nx = dec;
      if (dec == '0) begin
        done_nx  = 1'b1;
        state_nx = ST_DONE;
      end else begin
        state_nx = ST_RUNNING;
      end
    end else if (do_entry) begin
      digits_nx = {digits[NUM_DIGITS-2:0], digit};
      state_nx  = ({digits[NUM_DIGITS-2:0], digit} != '0) ? ST_ARMED : ST_IDLE;
    end else if (enable && !time_zero) begin
      state_nx = ST_RUNNING;
    end else if (!enable && state == ST_RUNNING) begin
      state_nx = ST_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits     <= '0;
      state      <= ST_IDLE;
      done_pulse <= 1'b0;
    end else begin
      digits     <= digits_nx;
      state      <= state_nx;
      done_pulse <= done_nx;
    end
  end

  assign sec_ones   = digits[0];
  assign sec_tens   = digits[1];
  assign min_ones   = digits[2];
  assign min_tens   = digits[3];
  assign timer_done = time_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer using the external tick input.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst, tick, enable, clearn, digit_valid;
  logic [3:0] digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] disp;
    logic        dp;
    logic        td;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];

  countdown_timer dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .enable      (enable),
    .clearn      (clearn),
    .digit_valid (digit_valid),
    .digit       (digit),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .timer_done  (timer_done),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  // Drive one cycle; push the expected post-edge view, capture the actual.
  task automatic cyc(input logic r, tk, en, cn, dv, input logic [3:0] d,
                     input logic [15:0] edisp, input logic edp);
    obs_t e, a;
    rst = r; tick = tk; enable = en; clearn = cn; digit_valid = dv; digit = d;
    e.disp = edisp; e.dp = edp; e.td = (edisp == 16'h0000);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a.disp = {min_tens, min_ones, sec_tens, sec_ones};
    a.dp   = done_pulse;
    a.td   = timer_done;
    act_q.push_back(a);
  endtask

  task automatic test_reset();
    obs_t e, a;
    int n = 0;
    cyc(1, 1, 0, 1, 1, 4'd5, 16'h0000, 0);
    cyc(1, 1, 1, 1, 1, 4'd7, 16'h0000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  task automatic test_entry();
    obs_t e, a;
    int n = 0;
    cyc(0, 0, 0, 1, 1, 4'd1,  16'h0001, 0);
    cyc(0, 0, 0, 1, 1, 4'd3,  16'h0013, 0);
    cyc(0, 0, 0, 1, 1, 4'd0,  16'h0130, 0);
    cyc(0, 0, 0, 1, 1, 4'd12, 16'h0130, 0);
    cyc(0, 0, 0, 1, 1, 4'd15, 16'h0130, 0);
    cyc(0, 0, 0, 1, 0, 4'd7,  16'h0130, 0);
    cyc(0, 0, 0, 0, 0, 4'd0,  16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd1,  16'h0001, 0);
    cyc(0, 0, 0, 1, 1, 4'd2,  16'h0012, 0);
    cyc(0, 0, 0, 1, 1, 4'd3,  16'h0123, 0);
    cyc(0, 0, 0, 1, 1, 4'd4,  16'h1234, 0);
    cyc(0, 0, 0, 1, 1, 4'd5,  16'h2345, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL entry step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  task automatic test_borrow();
    obs_t e, a;
    int n = 0;
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd1, 16'h0001, 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 16'h0010, 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 16'h0100, 0);
    cyc(0, 0, 1, 1, 0, 4'd0, 16'h0100, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0059, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0059, 0);
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd9, 16'h0009, 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 16'h0090, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0089, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0089, 0);
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd1, 16'h0001, 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 16'h0010, 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 16'h0100, 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 16'h1000, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0959, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0959, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL borrow step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  task automatic test_completion();
    obs_t e, a;
    int n = 0;
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd2, 16'h0002, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0001, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0000, 1);
    cyc(0, 0, 1, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL completion step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  task automatic test_pause();
    obs_t e, a;
    int n = 0;
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd5, 16'h0005, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0004, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0003, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 4'd0, 16'h0003, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0002, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0001, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0000, 1);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL pause step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  task automatic test_conflicts();
    obs_t e, a;
    int n = 0;
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd4, 16'h0004, 0);
    cyc(0, 1, 1, 0, 1, 4'd7, 16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 1, 1, 1, 4'd3, 16'h0000, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd1, 16'h0001, 0);
    cyc(0, 1, 1, 0, 1, 4'd2, 16'h0000, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd8, 16'h0008, 0);
    cyc(0, 0, 1, 1, 1, 4'd6, 16'h0008, 0);
    cyc(0, 1, 1, 1, 1, 4'd6, 16'h0007, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0007, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL conflicts step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  task automatic test_reset_midcount();
    obs_t e, a;
    int n = 0;
    cyc(0, 0, 0, 0, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 1, 4'd2, 16'h0002, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0001, 0);
    cyc(1, 1, 1, 1, 1, 4'd9, 16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 1, 1, 1, 0, 4'd0, 16'h0000, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'h0000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++; n++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset_midcount step%0d got disp=%h dp=%b td=%b want disp=%h dp=%b td=%b",
                 n, a.disp, a.dp, a.td, e.disp, e.dp, e.td);
      end
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; enable = 1'b0; clearn = 1'b1;
    digit_valid = 1'b0; digit = 4'd0;
    test_reset();
    test_entry();
    test_borrow();
    test_completion();
    test_pause();
    test_conflicts();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: TICK_DIV, default 0, meaning 0 = use external tick input; N>0 = internal 1 Hz tick every N clk cycles, with the tick input ignored.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-cycle countdown strobe (1 Hz), used when TICK_DIV=0.
REQ-005 enable  input  1  count permitted; driven by magnetron_on from the magnetron control stage.
REQ-006 clearn  input  1  active-low clear of the entered time.
REQ-007 digit_valid  input  1  one-cycle strobe, keypad digit present.
REQ-008 digit  input  4  BCD keypad digit.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD mm:ss display value, registered.
REQ-010 timer_done  output  1  high whenever the held time is 00:00; feeds the set/reset logic stage.
REQ-011 done_pulse  output  1  one-cycle strobe when the countdown reaches 00:00.

Function
REQ-012 State: IDLE (time 0, not counting), ARMED (time != 0, enable=0), RUNNING (enable=1, time != 0), DONE (reached 0 by countdown); state is held in a registered 2-bit encoding.
REQ-013 Per-cycle priority: rst > clearn=0 > countdown > digit entry.
REQ-014 clearn=0: all four digits go to 0 next cycle; state goes to IDLE; no done_pulse.
REQ-015 Digit entry: accepted only when enable=0, digit_valid=1 and digit<=9, in IDLE, ARMED or DONE.
REQ-016 Digit entry shifts left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; the old min_tens is discarded.
REQ-017 After digit entry, state becomes ARMED if the result is non-zero, otherwise IDLE.
REQ-018 Digits >9 and entries made while enable=1 are ignored, with no state change.
REQ-019 Countdown: on an effective tick with enable=1 and time != 0, decrement by one second in the same edge.
REQ-020 Borrow rules: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones; min_ones 0->9 borrows from min_tens.
REQ-021 Entered sec_tens values of 6-9 are legal and decrement normally, e.g. 00:90 -> 00:89.
REQ-022 Tick with enable=0: time holds.
REQ-023 Tick with time=0: no change and no borrow underflow; the time never wraps below 00:00.
REQ-024 done_pulse is high for exactly the cycle after the decrement yields 00:00; state then goes to DONE.
REQ-025 timer_done is combinationally equal to (all digits == 0) on the registered outputs, with zero added latency.
REQ-026 enable falling mid-count (door opened or stop) freezes the time; RUNNING goes to ARMED; enable rising resumes from the held value.
REQ-027 Internal tick (TICK_DIV>0): the prescaler counts only while enable=1, and holds its value when enable=0.
REQ-028 Internal tick prescaler is cleared by rst or clearn=0.

Reset
REQ-029 rst=1 at a clock edge: all digits 0, state IDLE, prescaler 0, done_pulse 0; timer_done therefore reads 1.
REQ-030 rst asserted mid-count aborts the countdown with no done_pulse.
REQ-031 All inputs are ignored while rst=1.

Structure
REQ-032 State encodings, BCD limits (9, 5) and the default TICK_DIV live in a shared microwave_defs include used by all oven stages.
REQ-033 One sub-module bcd_digit_down (inputs: value, max, borrow_in; outputs: next value, borrow_out) is instantiated four times, chained.
REQ-034 RTL target is 120-400 lines, fully synchronous, with no latches.

Verification
REQ-035 Reset: rst for 2 cycles -> digits 0000, timer_done=1, done_pulse=0.
REQ-036 Entry: digits 1,3,0 with enable=0 -> display 01:30 and timer_done=0; digit 12 -> display unchanged.
REQ-037 Borrow: load 01:00, enable=1, one tick -> 00:59; load 00:90, one tick -> 00:89.
REQ-038 Completion: load 00:02, enable=1, 2 ticks -> 00:00; done_pulse high exactly one cycle; timer_done=1; a further tick keeps 00:00.
REQ-039 Pause: load 00:05, 2 ticks, drop enable, 3 ticks -> holds 00:03; re-enable, 3 ticks -> 00:00.
REQ-040 Conflicts: clearn=0 together with a tick and a digit -> 00:00, no done_pulse; digit entry with enable=1 -> ignored.
